rtc_bus_ctrl: RTL and testbench

- Downstream consumer of the PicoBlaze output-port register block.
- Watches the contro_escribe, contro_lee and contro_listo flags, together with the latched Dir/Dato bytes.
- Executes one multiplexed address/data transaction on the external RTC parallel bus (CS/RD/WR/AD, 8-bit bidirectional).
- Returns read data for the PicoBlaze input port, then drives the 3-bit flag-clear code back to the register block.

---
 rtl/rtc_bus_ctrl.sv | 148 ++++++++++++++
 tb/tb_rtc_bus_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_ctrl.sv
// Multiplexed address/data RTC bus sequencer fed by the PicoBlaze output registers.
// Runs one timed write or read cycle per request flag, then holds a flag-clear code until the flag drops.
module rtc_bus_ctrl #(
    parameter int T_SU  = 2,
    parameter int T_PW  = 4,
    parameter int T_HD  = 2,
    parameter int T_GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] Dir,
    input  logic [7:0] Dato,
    input  logic       contro_escribe,
    input  logic       contro_lee,
    input  logic       contro_listo,
    output logic [2:0] rst_flags,
    inout  wire  [7:0] ad_bus,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_n,
    output logic [7:0] dato_leido,
    output logic       dato_valido,
    output logic       ocupado,
    output logic       listo_ack
);

    typedef enum logic [3:0] {IDLE, A_SU, A_STB, A_HD, GAP, D_SU, D_STB, D_HD, CLR} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       op_wr_q, op_wr_d;
    logic [7:0] dir_q, dir_d;
    logic [7:0] dato_q, dato_d;
    logic [7:0] leido_q, leido_d;
    logic [2:0] code_q, code_d;
    logic       valido_q, valido_d;
    logic       ack_q, ack_d;
    logic       clr_flag;
    logic       bus_oe;
    logic [7:0] bus_out;

    // Each timed state counts down from its duration minus one; untimed states park at zero.
    function automatic logic [3:0] load_val(input state_t s);
        case (s)
            A_SU, D_SU:   load_val = 4'(T_SU - 1);
            A_STB, D_STB: load_val = 4'(T_PW - 1);
            A_HD, D_HD:   load_val = 4'(T_HD - 1);
            GAP:          load_val = 4'(T_GAP - 1);
            default:      load_val = 4'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            op_wr_q  <= 1'b0;
            dir_q    <= 8'h00;
            dato_q   <= 8'h00;
            leido_q  <= 8'h00;
            code_q   <= 3'b000;
            valido_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_wr_q  <= op_wr_d;
            dir_q    <= dir_d;
            dato_q   <= dato_d;
            leido_q  <= leido_d;
            code_q   <= code_d;
            valido_q <= valido_d;
            ack_q    <= ack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_wr_d  = op_wr_q;
        dir_d    = dir_q;
        dato_d   = dato_q;
        leido_d  = leido_q;
        code_d   = code_q;
        valido_d = valido_q;
        ack_d    = 1'b0;
        case (code_q)
            3'b011:  clr_flag = contro_escribe;
            3'b010:  clr_flag = contro_lee;
            default: clr_flag = contro_listo;
        endcase
        case (state_q)
            IDLE: begin
                if (contro_escribe || contro_lee) begin
                    state_d  = A_SU;
                    op_wr_d  = contro_escribe;
                    code_d   = contro_escribe ? 3'b011 : 3'b010;
                    dir_d    = Dir;
                    dato_d   = Dato;
                    valido_d = 1'b0;
                end else if (contro_listo) begin
                    state_d = CLR;
                    code_d  = 3'b001;
                    ack_d   = 1'b1;
                end
            end
            A_SU:  if (cnt_q == 4'd0) state_d = A_STB;
            A_STB: if (cnt_q == 4'd0) state_d = A_HD;
            A_HD:  if (cnt_q == 4'd0) state_d = GAP;
            GAP:   if (cnt_q == 4'd0) state_d = D_SU;
            D_SU:  if (cnt_q == 4'd0) state_d = D_STB;
            D_STB: begin
                // Read data is taken at the end of the strobe, when the RTC output has settled longest.
                if (cnt_q == 4'd0) begin
                    state_d = D_HD;
                    if (!op_wr_q) begin
                        leido_d  = ad_bus;
                        valido_d = 1'b1;
                    end
                end
            end
            D_HD:  if (cnt_q == 4'd0) state_d = CLR;
            CLR:   if (!clr_flag) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = load_val(state_d);
        else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else cnt_d = 4'd0;
    end

    always_comb begin
        cs_n      = !(state_q inside {A_SU, A_STB, A_HD, GAP, D_SU, D_STB, D_HD});
        ad_n      = !(state_q inside {A_SU, A_STB, A_HD});
        wr_n      = !((state_q == A_STB) || (state_q == D_STB && op_wr_q));
        rd_n      = !(state_q == D_STB && !op_wr_q);
        bus_oe    = (state_q inside {A_SU, A_STB, A_HD}) ||
                    ((state_q inside {D_SU, D_STB, D_HD}) && op_wr_q);
        bus_out   = (state_q inside {A_SU, A_STB, A_HD}) ? dir_q : dato_q;
        rst_flags = (state_q == CLR) ? code_q : 3'b000;
        ocupado   = (state_q != IDLE);
    end

    assign ad_bus      = bus_oe ? bus_out : 8'bz;
    assign dato_leido  = leido_q;
    assign dato_valido = valido_q;
    assign listo_ack   = ack_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench for rtc_bus_ctrl: transaction table plus listo, mid-op reset and fast-timing sequences.
// Pull-ups make a released bus read back as 8'hFF; the bench acts as the RTC while rd_n is low.
module tb_rtc_bus_ctrl;

    localparam int TSU = 2, TPW = 4, THD = 2, TGAP = 2;
    localparam int A_END  = TSU + TPW + THD;
    localparam int G_END  = A_END + TGAP;
    localparam int CS_LEN = G_END + TSU + TPW + THD;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dir, dato, rd_val;
    logic       esc, lee, listo;
    logic [2:0] rst_flags;
    wire  [7:0] ad_bus;
    logic       cs_n, rd_n, wr_n, ad_n, dato_valido, ocupado, listo_ack;
    logic [7:0] dato_leido;

    logic [7:0] f_dir, f_dato;
    logic       f_esc, f_lee;
    logic [2:0] f_rst_flags;
    wire  [7:0] f_ad_bus;
    logic       f_cs_n, f_rd_n, f_wr_n, f_ad_n, f_dato_valido, f_ocupado, f_listo_ack;
    logic [7:0] f_dato_leido;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    assign ad_bus   = rd_n   ? 8'bz : rd_val;
    assign f_ad_bus = f_rd_n ? 8'bz : 8'h5C;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (ad_bus[g]);
        pullup (f_ad_bus[g]);
    end

    rtc_bus_ctrl dut (
        .clk(clk), .rst(rst), .Dir(dir), .Dato(dato),
        .contro_escribe(esc), .contro_lee(lee), .contro_listo(listo),
        .rst_flags(rst_flags), .ad_bus(ad_bus), .cs_n(cs_n), .rd_n(rd_n),
        .wr_n(wr_n), .ad_n(ad_n), .dato_leido(dato_leido),
        .dato_valido(dato_valido), .ocupado(ocupado), .listo_ack(listo_ack)
    );

    rtc_bus_ctrl #(.T_SU(1), .T_PW(1), .T_HD(1), .T_GAP(1)) dut_fast (
        .clk(clk), .rst(rst), .Dir(f_dir), .Dato(f_dato),
        .contro_escribe(f_esc), .contro_lee(f_lee), .contro_listo(1'b0),
        .rst_flags(f_rst_flags), .ad_bus(f_ad_bus), .cs_n(f_cs_n), .rd_n(f_rd_n),
        .wr_n(f_wr_n), .ad_n(f_ad_n), .dato_leido(f_dato_leido),
        .dato_valido(f_dato_valido), .ocupado(f_ocupado), .listo_ack(f_listo_ack)
    );

    typedef struct {
        logic       esc;
        logic       lee;
        logic       is_wr;
        logic [7:0] dir;
        logic [7:0] dato;
        logic [7:0] rdval;
        logic [2:0] exp_flags;
        logic       exp_valido;
        logic [7:0] exp_leido;
    } txn_t;

    txn_t tbl[4];
    txn_t rst_txn;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic l, input logic ls,
                                 input logic [7:0] d, input logic [7:0] dt);
        rst   = r;
        esc   = e;
        lee   = l;
        listo = ls;
        dir   = d;
        dato  = dt;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Walks one full bus cycle, checking {cs_n, ad_n, wr_n, rd_n, ad_bus} every clock, then the CLR handshake.
    task automatic runTxn(input txn_t t, input string tag);
        logic       e_ad, e_wr, e_rd;
        logic [7:0] e_bus;
        int         dk;
        rd_val = t.rdval;
        applyStimulus(1'b0, t.esc, t.lee, 1'b0, t.dir, t.dato);
        tick();
        for (int k = 0; k < CS_LEN; k++) begin
            e_ad  = (k >= A_END);
            e_wr  = 1'b1;
            e_rd  = 1'b1;
            e_bus = 8'hFF;
            if (k < A_END) begin
                e_bus = t.dir;
                if (k >= TSU && k < TSU + TPW) e_wr = 1'b0;
            end else if (k >= G_END) begin
                dk = k - G_END;
                if (t.is_wr) begin
                    e_bus = t.dato;
                    if (dk >= TSU && dk < TSU + TPW) e_wr = 1'b0;
                end else if (dk >= TSU && dk < TSU + TPW) begin
                    e_rd  = 1'b0;
                    e_bus = t.rdval;
                end
            end
            checkOutput($sformatf("%s_cyc%0d", tag, k),
                        {4'h0, cs_n, ad_n, wr_n, rd_n, ad_bus},
                        {4'h0, 1'b0, e_ad, e_wr, e_rd, e_bus});
            tick();
        end
        checkOutput({tag, "_clr"}, {2'b00, cs_n, ocupado, 1'b0, rst_flags, ad_bus},
                    {2'b00, 1'b1, 1'b1, 1'b0, t.exp_flags, 8'hFF});
        checkOutput({tag, "_rdata"}, {7'h00, dato_valido, dato_leido},
                    {7'h00, t.exp_valido, t.exp_leido});
        tick();
        checkOutput({tag, "_clr_hold"}, {13'h0, rst_flags}, {13'h0, t.exp_flags});
        if (t.is_wr) esc = 1'b0;
        else         lee = 1'b0;
        tick();
        checkOutput({tag, "_idle"}, {11'h0, cs_n, ocupado, rst_flags},
                    {11'h0, 1'b1, 1'b0, 3'b000});
    endtask

    // Fast-timing instance: counts chip-select and strobe cycles over a bounded window.
    task automatic runFast(input logic wr_op, input string tag);
        int cs = 0, wrl = 0, rdl = 0, run = 0, maxrun = 0;
        f_dir  = 8'h6B;
        f_dato = 8'h91;
        f_esc  = wr_op;
        f_lee  = !wr_op;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (!f_cs_n) cs++;
            if (!f_wr_n) wrl++;
            if (!f_rd_n) rdl++;
            if (!f_wr_n || !f_rd_n) run++;
            else run = 0;
            if (run > maxrun) maxrun = run;
        end
        checkOutput({tag, "_cs_cycles"}, 16'(cs), 16'd7);
        checkOutput({tag, "_wr_cycles"}, 16'(wrl), wr_op ? 16'd2 : 16'd1);
        checkOutput({tag, "_rd_cycles"}, 16'(rdl), wr_op ? 16'd0 : 16'd1);
        checkOutput({tag, "_strobe_width"}, 16'(maxrun), 16'd1);
        checkOutput({tag, "_flags"}, {13'h0, f_rst_flags}, {13'h0, wr_op ? 3'b011 : 3'b010});
        if (!wr_op) checkOutput({tag, "_rdata"}, {8'h00, f_dato_leido}, 16'h005C);
        f_esc = 1'b0;
        f_lee = 1'b0;
        tick();
        tick();
        checkOutput({tag, "_idle"}, {12'h0, f_cs_n, f_ocupado, 2'b00}, {12'h0, 1'b1, 1'b0, 2'b00});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        tbl[0] = '{esc: 1'b1, lee: 1'b0, is_wr: 1'b1, dir: 8'h21, dato: 8'h45, rdval: 8'h00,
                   exp_flags: 3'b011, exp_valido: 1'b0, exp_leido: 8'h00};
        tbl[1] = '{esc: 1'b0, lee: 1'b1, is_wr: 1'b0, dir: 8'h22, dato: 8'h00, rdval: 8'h37,
                   exp_flags: 3'b010, exp_valido: 1'b1, exp_leido: 8'h37};
        tbl[2] = '{esc: 1'b1, lee: 1'b1, is_wr: 1'b1, dir: 8'h5A, dato: 8'hC3, rdval: 8'h00,
                   exp_flags: 3'b011, exp_valido: 1'b0, exp_leido: 8'h37};
        tbl[3] = '{esc: 1'b0, lee: 1'b1, is_wr: 1'b0, dir: 8'h7E, dato: 8'h00, rdval: 8'h9C,
                   exp_flags: 3'b010, exp_valido: 1'b1, exp_leido: 8'h9C};
        rst_txn = '{esc: 1'b1, lee: 1'b0, is_wr: 1'b1, dir: 8'h33, dato: 8'h44, rdval: 8'h00,
                    exp_flags: 3'b011, exp_valido: 1'b0, exp_leido: 8'h00};

        rd_val = 8'h00;
        f_dir  = 8'h00;
        f_dato = 8'h00;
        f_esc  = 1'b0;
        f_lee  = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        checkOutput("reset_strobes", {8'h00, cs_n, rd_n, wr_n, ad_n, rst_flags, 1'b0},
                    {8'h00, 4'b1111, 3'b000, 1'b0});
        checkOutput("reset_bus", {8'h00, ad_bus}, 16'h00FF);
        checkOutput("reset_status", {4'h0, dato_leido, dato_valido, ocupado, listo_ack, 1'b0},
                    16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();

        for (int i = 0; i < 4; i++) runTxn(tbl[i], $sformatf("txn%0d", i));

        // listo alone: one-cycle ack, clear code 001, no bus activity
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        tick();
        checkOutput("listo_enter", {5'h0, listo_ack, cs_n, ocupado, rst_flags, 5'h0},
                    {5'h0, 1'b1, 1'b1, 1'b1, 3'b001, 5'h0});
        checkOutput("listo_bus", {8'h00, ad_bus}, 16'h00FF);
        tick();
        checkOutput("listo_hold", {5'h0, listo_ack, cs_n, ocupado, rst_flags, 5'h0},
                    {5'h0, 1'b0, 1'b1, 1'b1, 3'b001, 5'h0});
        listo = 1'b0;
        tick();
        checkOutput("listo_idle", {12'h0, ocupado, rst_flags}, 16'h0000);

        // reset during the address strobe of a write, then the write reruns
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 8'h44);
        tick();
        tick();
        tick();
        checkOutput("rstmid_in_astb", {12'h0, cs_n, wr_n, ad_n, 1'b0}, 16'h0000);
        rst = 1'b1;
        tick();
        checkOutput("rstmid_strobes", {8'h00, cs_n, rd_n, wr_n, ad_n, rst_flags, ocupado},
                    {8'h00, 4'b1111, 3'b000, 1'b0});
        checkOutput("rstmid_bus", {8'h00, ad_bus}, 16'h00FF);
        rst = 1'b0;
        runTxn(rst_txn, "rerun");

        runFast(1'b1, "fast_wr");
        runFast(1'b0, "fast_rd");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
